mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Multicycle MIPS main control FSM; sits directly upstream of the ALU control decoder and drives its 2-bit alu_op.
//  Sequences fetch/decode/execute/memory/writeback per instruction from the IR opcode; emits datapath mux/enable strobes.
//  Memory accesses use a req/ready handshake, so fetch and load/store stall for variable latency.
// PARAMETERS
//  MEM_HANDSHAKE  1  1: memory states wait for mem_ready; 0: mem_ready ignored, every access completes in 1 cycle
// PORTS
//  clk            in   1  system clock, rising edge
//  rst_n          in   1  asynchronous active-low reset
//  opcode         in   6  IR[31:26], stable from DECODE until the next FETCH
//  mem_ready      in   1  memory has completed the current read/write this cycle
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load if ALU zero (beq)
//  i_or_d         out  1  memory address mux: 0=PC, 1=ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  instruction register load
//  mem_to_reg     out  1  regfile write data: 0=ALUOut, 1=MDR
//  reg_dst        out  1  regfile write address: 0=rt, 1=rd
//  reg_write      out  1  regfile write enable
//  alu_src_a      out  1  0=PC, 1=A
//  alu_src_b      out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  alu_op         out  2  00=add, 01=sub, 10=decode funct (to the ALU control decoder)
//  pc_source      out  2  00=ALU result, 01=ALUOut, 10=jump target
//  illegal_op     out  1  1-cycle pulse in DECODE on unsupported opcode
//  instr_done     out  1  1-cycle pulse on the last cycle of each instruction
//  state_o        out  4  current state encoding, debug
// BEHAVIOUR
//  Reset (async, rst_n=0): state=RESET; every output 0. First clock after release: RESET->FETCH.
//  Moore outputs decoded from the state register, except ir_write/pc_write in FETCH (qualified by mem_ready).
//  FETCH: mem_read=1, i_or_d=0, src_a=0, src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; ->DECODE on mem_ready, else hold.
//  DECODE: src_a=0, src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
//   000000(R)->EXECUTE; 100011(lw)/101011(sw)->MEM_ADDR; 000100(beq)->BRANCH; 000010(j)->JUMP; other->FETCH with illegal_op=1.
//  MEM_ADDR: src_a=1, src_b=10, alu_op=00; lw->MEM_READ, sw->MEM_WRITE.
//  MEM_READ: mem_read=1, i_or_d=1; ->MEM_WB on mem_ready, else hold.
//  MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; ->FETCH.
//  MEM_WRITE: mem_write=1, i_or_d=1; on mem_ready: instr_done=1, ->FETCH; else hold.
//  EXECUTE: src_a=1, src_b=00, alu_op=10; ->R_WB.  R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; ->FETCH.
//  BRANCH: src_a=1, src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1; ->FETCH.
//  JUMP: pc_write=1, pc_source=10, instr_done=1; ->FETCH.
//  Unlisted outputs are 0 in every state. mem_read and mem_write are never both 1. Unreachable state encodings -> FETCH.
//  Latency with 0-wait memory: R=4, lw=5, sw=4, beq=3, j=3 cycles.
//  mem_read/mem_write stay asserted through stalls. Reset mid-instruction aborts it; no pulse is emitted.
// CONFIGURATION
//  ADDI_EN defined: opcode 001000 -> ADDI_EXEC (src_a=1, src_b=10, alu_op=00) -> ADDI_WB (reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1) -> FETCH.
//  ADDI_EN undefined: 001000 is illegal (illegal_op pulse, ->FETCH).
// STRUCTURE
//  Shared package mips_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), ALU_OP_ADD/SUB/FUNCT, mux-select constants, state encoding.
//  No sub-module: state register, next-state logic and output decode stay in one module.
// TESTING
//  Reset held, then released with mem_ready=1 -> all outputs 0 during reset; FETCH next cycle with mem_read=1, ir_write=1, pc_write=1.
//  R-type (000000), mem_ready=1 -> states FETCH,DECODE,EXECUTE(alu_op=10),R_WB(reg_write=1, reg_dst=1); instr_done on cycle 4.
//  lw, mem_ready low for 3 cycles in MEM_READ -> hold with mem_read=1, i_or_d=1; MEM_WB after ready; reg_write=1, mem_to_reg=1.
//  beq then j -> BRANCH: alu_op=01, pc_write_cond=1, pc_source=01; JUMP: pc_write=1, pc_source=10; each 3 cycles.
//  Opcode 111111 -> illegal_op pulse in DECODE, back to FETCH, no reg_write/mem_write; repeat with 001000 per ADDI_EN setting.
//  rst_n dropped during a MEM_WRITE stall -> mem_write drops asynchronously; no instr_done; restart at FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALU op codes,
// datapath mux selects and the main-control state encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_REG       = 2'b00;
    localparam logic [1:0] SRC_B_FOUR      = 2'b01;
    localparam logic [1:0] SRC_B_IMM       = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SHIFT = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

endpackage

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM with req/ready memory stalls.
// Define ADDI_EN to add the addi instruction (ADDI_EXEC/ADDI_WB states).
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       instr_done,
    output logic [3:0] state_o
);

    state_t state;
    state_t next_state;
    logic   ready;

    // Without the handshake every memory access is treated as single-cycle.
    assign ready   = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign state_o = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_RESET:     next_state = S_FETCH;
            S_FETCH:     next_state = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      next_state = S_ADDI_EXEC;
`endif
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    next_state = S_MEM_READ;
                end else if (opcode == OP_SW) begin
                    next_state = S_MEM_WRITE;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_MEM_READ:  next_state = ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    next_state = S_FETCH;
            S_MEM_WRITE: next_state = ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   next_state = S_R_WB;
            S_R_WB:      next_state = S_FETCH;
            S_BRANCH:    next_state = S_FETCH;
            S_JUMP:      next_state = S_FETCH;
`ifdef ADDI_EN
            S_ADDI_EXEC: next_state = S_ADDI_WB;
            S_ADDI_WB:   next_state = S_FETCH;
`endif
            default:     next_state = S_FETCH;
        endcase
    end

    // Outputs follow the state register, so an async reset clears them at once;
    // only the fetch loads and the store/decode pulses look at live inputs.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALU_OP_ADD;
        pc_source     = PC_SRC_ALU;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = ready;
                pc_write  = ready;
            end
            S_DECODE: begin
                alu_src_b = SRC_B_IMM_SHIFT;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: illegal_op = 1'b0;
`ifdef ADDI_EN
                    OP_ADDI: illegal_op = 1'b0;
`endif
                    default: illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = ready;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PC_SRC_JUMP;
                instr_done = 1'b1;
            end
`ifdef ADDI_EN
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
`endif
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: a per-instruction cycle model pushes
// expected control vectors, a negedge monitor pops and compares them.
module tb_mips_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       instr_done;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_o;

    ctl_t  actual;
    ctl_t  expQ[$];
    string tagQ[$];
    int    vectors = 0;
    int    compares = 0;
    int    miscompares = 0;
    bit    checkEn = 1'b0;

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .instr_done(instr_done),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign actual = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source, illegal_op, instr_done};

    function automatic bit isLegal(input logic [5:0] op);
        bit addiOk;
`ifdef ADDI_EN
        addiOk = 1'b1;
`else
        addiOk = 1'b0;
`endif
        return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
               (op == 6'b000100) || (op == 6'b000010) || (addiOk && op == 6'b001000);
    endfunction

    task automatic applyStimulus(input bit rstVal, input bit rdy, input logic [5:0] op,
                                 input ctl_t e, input string tag);
        @(posedge clk);
        #1;
        rst_n     = rstVal;
        mem_ready = rdy;
        opcode    = op;
        expQ.push_back(e);
        tagQ.push_back(tag);
        vectors++;
    endtask

    task automatic checkOutput();
        ctl_t  e;
        string t;
        if (expQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_underflow: got %h required an expected entry", actual);
        end else begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            compares++;
            if (actual !== e) begin
                miscompares++;
                $display("[TB] FAIL %s: got %h required %h (t=%0t)", t, actual, e, $time);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (checkEn) checkOutput();
        end
    end

    // Cycle-by-cycle picture of one instruction; abortStall stops inside a store stall.
    task automatic runInstr(input logic [5:0] op, input int fStall, input int mStall,
                            input bit abortStall);
        ctl_t e;
        for (int k = 0; k < fStall; k++) begin
            e = '0; e.mem_read = 1; e.alu_src_b = 2'b01;
            applyStimulus(1, 0, op, e, "fetch_stall");
        end
        e = '0; e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = 1; e.pc_write = 1;
        applyStimulus(1, 1, op, e, "fetch");
        e = '0; e.alu_src_b = 2'b11;
        if (!isLegal(op)) begin
            e.illegal_op = 1;
            applyStimulus(1, 1'($urandom_range(0, 1)), op, e, "decode_illegal");
            return;
        end
        applyStimulus(1, 1'($urandom_range(0, 1)), op, e, "decode");
        case (op)
            6'b000000: begin
                e = '0; e.alu_src_a = 1; e.alu_op = 2'b10;
                applyStimulus(1, 1'($urandom_range(0, 1)), op, e, "r_execute");
                e = '0; e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1;
                applyStimulus(1, 1'($urandom_range(0, 1)), op, e, "r_wb");
            end
            6'b100011, 6'b101011: begin
                e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10;
                applyStimulus(1, 1'($urandom_range(0, 1)), op, e, "mem_addr");
                e = '0; e.i_or_d = 1;
                if (op == 6'b100011) e.mem_read = 1; else e.mem_write = 1;
                for (int k = 0; k < mStall; k++)
                    applyStimulus(1, 0, op, e, "mem_stall");
                if (abortStall) return;
                if (op == 6'b100011) begin
                    applyStimulus(1, 1, op, e, "lw_read");
                    e = '0; e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1;
                    applyStimulus(1, 1'($urandom_range(0, 1)), op, e, "lw_wb");
                end else begin
                    e.instr_done = 1;
                    applyStimulus(1, 1, op, e, "sw_write");
                end
            end
            6'b000100: begin
                e = '0; e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1;
                e.pc_source = 2'b01; e.instr_done = 1;
                applyStimulus(1, 1'($urandom_range(0, 1)), op, e, "beq");
            end
            6'b000010: begin
                e = '0; e.pc_write = 1; e.pc_source = 2'b10; e.instr_done = 1;
                applyStimulus(1, 1'($urandom_range(0, 1)), op, e, "jump");
            end
            default: begin
                e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10;
                applyStimulus(1, 1'($urandom_range(0, 1)), op, e, "addi_exec");
                e = '0; e.reg_write = 1; e.instr_done = 1;
                applyStimulus(1, 1'($urandom_range(0, 1)), op, e, "addi_wb");
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d entries pending", expQ.size());
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [5:0] opList [7];
        logic [5:0] op;
        opList = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
        checkEn = 1'b1;

        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 6'd0, '0, "reset_hold");
        applyStimulus(1, 1, 6'd0, '0, "reset_release");

        runInstr(6'b000000, 0, 0, 0);
        runInstr(6'b100011, 0, 3, 0);
        runInstr(6'b000100, 0, 0, 0);
        runInstr(6'b000010, 0, 0, 0);
        runInstr(6'b101011, 2, 1, 0);
        runInstr(6'b111111, 0, 0, 0);
        runInstr(6'b001000, 0, 0, 0);

        // Drop reset in the middle of a stalled store, then restart.
        runInstr(6'b101011, 0, 2, 1);
        applyStimulus(0, 0, 6'b101011, '0, "abort_reset");
        applyStimulus(0, 1, 6'b101011, '0, "abort_hold");
        applyStimulus(1, 1, 6'b000000, '0, "abort_release");
        runInstr(6'b000000, 0, 0, 0);

        for (int n = 0; n < 80; n++) begin
            op = opList[$urandom_range(0, 6)];
            if ($urandom_range(0, 5) == 0) op = 6'($urandom);
            runInstr(op, $urandom_range(0, 2), $urandom_range(0, 3), 0);
        end

        @(negedge clk);
        #1;
        checkEn = 1'b0;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
